// File: rtl/pio_bank_pkg.sv
// Shared definitions for the PIO bank: bus width, register map and debounce states.
package pio_bank_pkg;

  localparam int unsigned BUS_W = 32;

  localparam logic [2:0] ADDR_DATA_IN   = 3'd0;
  localparam logic [2:0] ADDR_DATA_OUT  = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK  = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP  = 3'd3;
  localparam logic [2:0] ADDR_OUT_SET   = 3'd4;
  localparam logic [2:0] ADDR_OUT_CLR   = 3'd5;
  localparam logic [2:0] ADDR_EDGE_MODE = 3'd6;

  typedef enum logic {
    DB_STABLE   = 1'b0,
    DB_SETTLING = 1'b1
  } db_state_e;

endpackage

// File: rtl/pio_debounce.sv
// Single-bit debouncer: synchronised input in, accepted value out.
// Debounce FSM is built only when PIO_BANK_DEBOUNCE_EN is defined; otherwise a pass-through.
module pio_debounce
  import pio_bank_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic din_i,
  output logic acc_o
);

`ifdef PIO_BANK_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          acc_q, acc_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DB_STABLE;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  // The first differing cycle counts as 1, so acceptance follows DEBOUNCE_CYCLES stable samples.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    if (load_i) begin
      state_d = DB_STABLE;
      cnt_d   = '0;
      acc_d   = din_i;
    end else begin
      case (state_q)
        DB_STABLE: begin
          if (din_i != acc_q) begin
            state_d = DB_SETTLING;
            cnt_d   = CW'(1);
          end
        end
        DB_SETTLING: begin
          if (din_i == acc_q) begin
            state_d = DB_STABLE;
            cnt_d   = '0;
          end else if (cnt_q >= LAST) begin
            state_d = DB_STABLE;
            cnt_d   = '0;
            acc_d   = din_i;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = DB_STABLE;
      endcase
    end
  end

  always_comb begin
    acc_o = load_i ? din_i : acc_q;
  end
`else
  localparam int unsigned unused_db_cycles = DEBOUNCE_CYCLES;
  logic unused_ctl;
  assign unused_ctl = clk ^ reset ^ load_i;

  always_comb begin
    acc_o = din_i;
  end
`endif

endmodule

// File: rtl/pio_bank.sv
// Avalon-MM PIO bank: synchronised/debounced inputs with edge capture and irq, registered outputs.
// Optional debounce FSM per input selected by PIO_BANK_DEBOUNCE_EN.
module pio_bank
  import pio_bank_pkg::*;
#(
  parameter int unsigned IN_WIDTH        = 4,
  parameter int unsigned OUT_WIDTH       = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           address,
  input  logic                 read,
  input  logic                 write,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  output logic                 irq,
  input  logic [IN_WIDTH-1:0]  pio_in,
  output logic [OUT_WIDTH-1:0] pio_out
);

  logic [IN_WIDTH-1:0]  sync1_q, sync2_q, acc, prev_q, edge_vec, wd_in, w1c;
  logic [IN_WIDTH-1:0]  mask_q, mask_d, cap_q, cap_d, mode_q, mode_d;
  logic [OUT_WIDTH-1:0] out_q, out_d, wd_out;
  logic [BUS_W-1:0]     rdata_q, rdata_d, rd_mux;
  logic                 irq_q, irq_d, first_q;
  logic                 unused_wd;

  assign wd_in     = writedata[IN_WIDTH-1:0];
  assign wd_out    = writedata[OUT_WIDTH-1:0];
  assign unused_wd = ^writedata;

  always_ff @(posedge clk) begin
    sync1_q <= pio_in;
    sync2_q <= sync1_q;
  end

  for (genvar i = 0; i < IN_WIDTH; i++) begin : g_db
    pio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .reset (reset),
      .load_i(first_q),
      .din_i (sync2_q[i]),
      .acc_o (acc[i])
    );
  end

  // first_q marks the cycle after reset: accepted value loads and edges are suppressed.
  always_ff @(posedge clk) begin
    first_q <= reset;
    prev_q  <= acc;
  end

  assign edge_vec = first_q ? '0
                  : ((acc & ~prev_q & ~mode_q) | (~acc & prev_q & mode_q));

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA_IN:   rd_mux[IN_WIDTH-1:0]  = acc;
      ADDR_DATA_OUT:  rd_mux[OUT_WIDTH-1:0] = out_q;
      ADDR_IRQ_MASK:  rd_mux[IN_WIDTH-1:0]  = mask_q;
      ADDR_EDGE_CAP:  rd_mux[IN_WIDTH-1:0]  = cap_q;
      ADDR_EDGE_MODE: rd_mux[IN_WIDTH-1:0]  = mode_q;
      default:        rd_mux = '0;
    endcase
    rdata_d = read ? rd_mux : '0;

    out_d  = out_q;
    mask_d = mask_q;
    mode_d = mode_q;
    w1c    = '0;
    if (write) begin
      case (address)
        ADDR_DATA_OUT:  out_d  = wd_out;
        ADDR_IRQ_MASK:  mask_d = wd_in;
        ADDR_EDGE_CAP:  w1c    = wd_in;
        ADDR_OUT_SET:   out_d  = out_q | wd_out;
        ADDR_OUT_CLR:   out_d  = out_q & ~wd_out;
        ADDR_EDGE_MODE: mode_d = wd_in;
        default:        out_d  = out_q;
      endcase
    end
    cap_d = (cap_q & ~w1c) | edge_vec;
    irq_d = |(cap_q & mask_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q   <= '0;
      mask_q  <= '0;
      cap_q   <= '0;
      mode_q  <= '0;
      irq_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      out_q   <= out_d;
      mask_q  <= mask_d;
      cap_q   <= cap_d;
      mode_q  <= mode_d;
      irq_q   <= irq_d;
      rdata_q <= rdata_d;
    end
  end

  assign pio_out  = out_q;
  assign irq      = irq_q;
  assign readdata = rdata_q;

endmodule
